// File: rtl/object_buffer_if.sv
// rtl/object_buffer_if.sv - fetch-side and decode-side handshake bundle for object_buffer
interface object_buffer_if;
    logic         ob_valid;
    logic [127:0] entry;
    logic         ob_full;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_entry;
    logic         out_nested;

    modport master (
        output ob_valid, entry, out_ready,
        input  ob_full, out_valid, out_entry, out_nested
    );

    modport slave (
        input  ob_valid, entry, out_ready,
        output ob_full, out_valid, out_entry, out_nested
    );
endinterface

// File: rtl/object_buffer.sv
// rtl/object_buffer.sv - show-ahead TABLE_ENTRY FIFO between fetch and decode
module object_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    object_buffer_if.slave    ob,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [127:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             blocked_q, blocked_d;
    logic             full, not_empty, push, pop;

    always_comb begin
        full       = (count_q == FULL_CNT);
        not_empty  = (count_q != '0);
        push       = ob.ob_valid & ~full;
        pop        = not_empty & ob.out_ready;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A blocked producer that withdraws while still full has dropped its entry.
        blocked_d  = ob.ob_valid & full;
        overflow_d = overflow_q | (blocked_q & ~ob.ob_valid & full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            blocked_q  <= blocked_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= ob.entry;
    end

    assign ob.ob_full    = full;
    assign ob.out_valid  = not_empty;
    assign ob.out_entry  = not_empty ? mem[rd_ptr_q] : 128'h0;
    assign ob.out_nested = not_empty & mem[rd_ptr_q][64];
    assign count         = count_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_object_buffer.sv
// tb/tb_object_buffer.sv - randomized and directed bench for object_buffer against a queue model
module tb_object_buffer;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] count;
    logic             overflow;
    object_buffer_if  obif();

    object_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .ob       (obif),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [127:0] mq[$];
    bit           m_ovf;
    bit           m_blk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_blk = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [127:0] head;
        head = (mq.size() != 0) ? mq[0] : 128'h0;
        check({tag, "_valid"},  128'(obif.out_valid),  128'(mq.size() != 0));
        check({tag, "_entry"},  obif.out_entry,        head);
        check({tag, "_nested"}, 128'(obif.out_nested), 128'(head[64]));
        check({tag, "_full"},   128'(obif.ob_full),    128'(mq.size() == DEPTH));
        check({tag, "_count"},  128'(count),           128'(mq.size()));
        check({tag, "_ovf"},    128'(overflow),        128'(m_ovf));
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge.
    task automatic cyc(input string tag, input bit v, input logic [127:0] e, input bit rdy);
        bit push, pop;
        obif.ob_valid  = v;
        obif.entry     = e;
        obif.out_ready = rdy;
        @(negedge clk);
        check_all(tag);
        push = v && (mq.size() < DEPTH);
        pop  = rdy && (mq.size() > 0);
        if (m_blk && !v && mq.size() == DEPTH) m_ovf = 1'b1;
        m_blk = v && (mq.size() == DEPTH);
        @(posedge clk);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(e);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int pushed;
        logic [127:0] e9;

        model_clear();
        rst_n          = 1'b0;
        obif.ob_valid  = 1'b1;
        obif.entry     = 128'hDEAD;
        obif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        @(posedge clk);
        #1;
        obif.ob_valid = 1'b0;
        rst_n = 1'b1;

        // Single entry with nested flag
        cyc("t2_push", 1'b1, 128'hA5A5A5A5_A5A5A5A5_00000000_00000001, 1'b0);
        cyc("t2_show", 1'b0, 128'h0, 1'b0);
        check("t2_nested", 128'(obif.out_nested), 128'd1);
        cyc("t2_pop",  1'b0, 128'h0, 1'b1);
        cyc("t2_empty", 1'b0, 128'h0, 1'b0);

        // Fill, hold a blocked 9th entry, pop one so it gets accepted
        for (int i = 0; i < DEPTH; i++) cyc("t3_fill", 1'b1, 128'(100 + i), 1'b0);
        e9 = 128'h9999;
        for (int i = 0; i < 3; i++) cyc("t3_hold", 1'b1, e9, 1'b0);
        cyc("t3_pop", 1'b1, e9, 1'b1);
        cyc("t3_acc", 1'b1, e9, 1'b0);
        cyc("t3_full", 1'b0, 128'h0, 1'b0);
        check("t3_count8", 128'(count), 128'(DEPTH));

        // Producer withdraws while full: entry lost, sticky flag
        cyc("ovf_a", 1'b1, 128'h7777, 1'b0);
        cyc("ovf_b", 1'b0, 128'h0, 1'b0);
        cyc("ovf_c", 1'b0, 128'h0, 1'b0);
        check("ovf_set", 128'(overflow), 128'd1);
        while (mq.size() != 0) cyc("drain", 1'b0, 128'h0, 1'b1);

        // Stream 0..19 with ready toggling, pointers wrap
        pushed = 0;
        for (int c = 0; c < 200 && (pushed < 20 || mq.size() != 0); c++) begin
            bit v;
            v = (pushed < 20);
            if (v && mq.size() < DEPTH) begin
                cyc("t4", 1'b1, 128'(pushed), c[0] == 1'b0);
                pushed++;
            end else begin
                cyc("t4", v, 128'(pushed), c[0] == 1'b0);
            end
        end
        check("t4_pushed", 128'(pushed), 128'd20);
        check("t4_drained", 128'(count), 128'd0);

        // Simultaneous push/pop at count=3
        for (int i = 0; i < 3; i++) cyc("t5_fill", 1'b1, 128'(200 + i), 1'b0);
        cyc("t5_both", 1'b1, 128'd203, 1'b1);
        cyc("t5_after", 1'b0, 128'h0, 1'b0);
        check("t5_count3", 128'(count), 128'd3);
        check("t5_head", obif.out_entry, 128'd201);
        while (mq.size() != 0) cyc("drain", 1'b0, 128'h0, 1'b1);

        // Randomized traffic including illegal withdrawals
        for (int c = 0; c < 400; c++)
            cyc("rnd", ($urandom_range(0, 3) != 0), rnd128(), ($urandom_range(0, 2) == 0));

        // Asynchronous reset mid-stream at count=5
        while (mq.size() != 0) cyc("drain", 1'b0, 128'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc("t6_fill", 1'b1, 128'(300 + i), 1'b0);
        obif.ob_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_count", 128'(count), 128'd0);
        check("t6_valid", 128'(obif.out_valid), 128'd0);
        check("t6_full",  128'(obif.ob_full), 128'd0);
        check("t6_entry", obif.out_entry, 128'h0);
        check("t6_ovf",   128'(overflow), 128'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("t6_push", 1'b1, 128'h6666, 1'b0);
        cyc("t6_head", 1'b0, 128'h0, 1'b0);
        check("t6_newhead", obif.out_entry, 128'h6666);
        check("t6_count1", 128'(count), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
